unified_mem_arbiter: RTL
========================

Name: unified_mem_arbiter

Overview:
Parametrised single-port memory subsystem that replaces separate single-cycle instruction and data memories. It owns one synchronous word RAM and arbitrates between the CPU instruction-fetch port and the data port. Each access takes a configurable number of wait states and uses a req/ready handshake, so the CPU stalls on ready instead of assuming zero latency. It sits between the CPU and the (removed) separate instruction and data memories in the system top.

Parameters:
ADDR_W, 32, byte-address width of both ports
DATA_W, 32, word width; must be a multiple of 8
DEPTH_LOG2, 10, log2 of RAM depth in words
WAIT_STATES, 1, extra cycles per access, legal range 0..7
DATA_PRIORITY, 1, 1 = data port always wins a conflict; 0 = round-robin

Ports:
clk_i  in  1  system clock, rising edge
rst_i  in  1  asynchronous, active-high reset
if_req_i  in  1  instruction fetch request; held until if_ready_o
if_addr_i  in  ADDR_W  fetch byte address
if_ready_o  out  1  one-cycle pulse: fetch complete
if_data_o  out  DATA_W  fetched word; valid with if_ready_o and held afterwards
d_read_i  in  1  data read request
d_write_i  in  1  data write request
d_addr_i  in  ADDR_W  data byte address
d_wdata_i  in  DATA_W  write data
d_be_i  in  DATA_W/8  byte enables for writes
d_ready_o  out  1  one-cycle pulse: data access complete
d_rdata_o  out  DATA_W  read word; valid with d_ready_o and held afterwards
busy_o  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is asynchronous and active-high on rst_i.
- Reset values: FSM in IDLE; all outputs 0; round-robin pointer favours the data port; wait counter 0. RAM contents are not reset.
- Word index is addr[DEPTH_LOG2+1:2]. Byte-offset bits are ignored. Upper bits alias.
- FSM states and transitions:
  - IDLE: sample requests. A data request is d_read_i|d_write_i.
    - If any request is present, grant one port. Latch its op, address, wdata and be. Load counter with WAIT_STATES. Go to WAIT.
    - With no request, stay in IDLE.
  - WAIT: if counter != 0, decrement it. If counter == 0, perform the RAM op on this edge and go to RESP.
    - Read: capture the word into the granted port's data register.
    - Write: update only the bytes whose d_be_i bit is 1.
  - RESP: assert the granted port's ready for exactly one cycle. Go to IDLE.
- Latency: request sampled at edge N -> ready high during cycle N+WAIT_STATES+2. Throughput is one access per WAIT_STATES+3 cycles.
- Handshake:
  - A requester keeps its req/address/data stable until it sees ready.
  - It deasserts req in the cycle after ready; a req still high in IDLE is treated as a new access.
  - Inputs are ignored outside IDLE because they are latched at grant.
  - A req dropped after grant does not abort; the access completes and ready still pulses.
- Arbitration on a simultaneous if_req_i and data request in IDLE:
  - DATA_PRIORITY=1: data is granted.
  - DATA_PRIORITY=0: grant alternates. The pointer flips to the other port after each conflict grant; it is unchanged when only one port requests.
- d_read_i and d_write_i both high: handled as a write only. d_rdata_o is unchanged and d_ready_o pulses once.
- A write with d_be_i==0 leaves RAM unchanged but still completes with a ready pulse.
- Data hold: if_data_o changes only on a completed fetch; d_rdata_o changes only on a completed read.
- Reset mid-operation: the FSM returns to IDLE immediately. A pending write not yet at counter==0 is not committed. No ready pulse is produced.
- A write performed by the data port is visible to any later fetch of the same word (single array, no forwarding hazard).

Test Plan:
- WAIT_STATES=1, data write 0xDEADBEEF to 0x10 with be=4'hF, then data read of 0x10 -> d_ready_o rises 3 cycles after each request is sampled; d_rdata_o=0xDEADBEEF.
- Word 0x10 = 0xDEADBEEF, write 0x00AA0000 with be=4'b0100 -> a subsequent read returns 0xDEAABEEF.
- DATA_PRIORITY=1, if_req_i and d_read_i asserted together and held -> d_ready_o first; if_ready_o follows WAIT_STATES+3 cycles later; no ready pulses overlap.
- DATA_PRIORITY=0, both ports requesting continuously for 4 accesses -> grants alternate D,I,D,I.
- WAIT_STATES=3, assert rst_i one cycle after a write is granted -> busy_o=0 and all ready outputs stay 0 asynchronously; a later read of that word returns its old value.
- WAIT_STATES=0, fetch of 0x10 and fetch of 0x1010 with DEPTH_LOG2=10 -> both return the same word (alias); ready arrives 2 cycles after the request is sampled.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter
//
// Single-port synchronous word RAM shared by the CPU instruction-fetch port and
// the data port. Each access is granted in IDLE, waits WAIT_STATES extra cycles,
// performs the RAM operation, then pulses the granted port's ready for exactly
// one cycle. The CPU stalls on ready instead of assuming zero latency.
//
// Parameters:
//   ADDR_W        byte-address width of both ports
//   DATA_W        word width (multiple of 8)
//   DEPTH_LOG2    log2 of RAM depth in words
//   WAIT_STATES   extra cycles per access (0..7)
//   DATA_PRIORITY 1 = data port wins every conflict, 0 = round-robin
//
// Ports:
//   clk_i       system clock, rising edge
//   rst_i       asynchronous active-high reset
//   if_req_i    fetch request, held until if_ready_o
//   if_addr_i   fetch byte address
//   if_ready_o  one-cycle pulse: fetch complete
//   if_data_o   fetched word, valid with if_ready_o and held afterwards
//   d_read_i    data read request
//   d_write_i   data write request (wins when both read and write are high)
//   d_addr_i    data byte address
//   d_wdata_i   write data
//   d_be_i      byte enables for writes
//   d_ready_o   one-cycle pulse: data access complete
//   d_rdata_o   read word, valid with d_ready_o and held afterwards
//   busy_o      high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module unified_mem_arbiter #(
   parameter int ADDR_W        = 32,
   parameter int DATA_W        = 32,
   parameter int DEPTH_LOG2    = 10,
   parameter int WAIT_STATES   = 1,
   parameter int DATA_PRIORITY = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  if_req_i,
   input  logic [ADDR_W-1:0]     if_addr_i,
   output logic                  if_ready_o,
   output logic [DATA_W-1:0]     if_data_o,
   input  logic                  d_read_i,
   input  logic                  d_write_i,
   input  logic [ADDR_W-1:0]     d_addr_i,
   input  logic [DATA_W-1:0]     d_wdata_i,
   input  logic [DATA_W/8-1:0]   d_be_i,
   output logic                  d_ready_o,
   output logic [DATA_W-1:0]     d_rdata_o,
   output logic                  busy_o
);

   localparam int NB    = DATA_W / 8;
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t                  state_r;
   state_t                  state_nxt_s;
   logic [2:0]              cnt_r;
   logic                    gnt_data_r;   // 1 = data port owns the current access
   logic                    op_write_r;
   logic [DEPTH_LOG2-1:0]   idx_r;
   logic [DATA_W-1:0]       wdata_r;
   logic [NB-1:0]           be_r;
   logic                    rr_data_r;    // round-robin pointer, 1 = data favoured

   logic                    d_req_s;
   logic                    any_req_s;
   logic                    conflict_s;
   logic                    grant_data_s;
   logic                    do_op_s;

   logic [DATA_W-1:0]       mem_r [DEPTH];

   // Replace only the enabled bytes of a stored word.
   function automatic logic [DATA_W-1:0] merge_bytes(
      input logic [DATA_W-1:0] old_word,
      input logic [DATA_W-1:0] new_word,
      input logic [NB-1:0]     be
   );
      logic [DATA_W-1:0] res;
      res = old_word;
      for (int b = 0; b < NB; b++) begin
         if (be[b]) begin
            res[8*b +: 8] = new_word[8*b +: 8];
         end else begin
            res[8*b +: 8] = old_word[8*b +: 8];
         end
      end
      return res;
   endfunction

   assign d_req_s    = d_read_i | d_write_i;
   assign any_req_s  = if_req_i | d_req_s;
   assign conflict_s = if_req_i & d_req_s;
   // The RAM operation happens on the edge that leaves WAIT with an expired counter.
   assign do_op_s    = (state_r == ST_WAIT) && (cnt_r == 3'd0);

   // Byte-offset and aliasing upper address bits never select a word.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{if_addr_i[ADDR_W-1:DEPTH_LOG2+2], if_addr_i[1:0],
                               d_addr_i[ADDR_W-1:DEPTH_LOG2+2], d_addr_i[1:0]};

   // Arbitration: pick the port to grant when sitting in IDLE.
   always_comb begin
      grant_data_s = 1'b0;
      if (conflict_s) begin
         if (DATA_PRIORITY != 0) begin
            grant_data_s = 1'b1;
         end else begin
            grant_data_s = rr_data_r;
         end
      end else begin
         grant_data_s = d_req_s;
      end
   end

   // Next-state logic of the IDLE -> WAIT -> RESP access sequence.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (any_req_s) begin
               state_nxt_s = ST_WAIT;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (cnt_r == 3'd0) begin
               state_nxt_s = ST_RESP;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         ST_RESP: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State register, grant latches, wait counter and registered outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r    <= ST_IDLE;
         cnt_r      <= 3'd0;
         gnt_data_r <= 1'b0;
         op_write_r <= 1'b0;
         idx_r      <= {DEPTH_LOG2{1'b0}};
         wdata_r    <= {DATA_W{1'b0}};
         be_r       <= {NB{1'b0}};
         rr_data_r  <= 1'b1;
         if_ready_o <= 1'b0;
         d_ready_o  <= 1'b0;
         if_data_o  <= {DATA_W{1'b0}};
         d_rdata_o  <= {DATA_W{1'b0}};
         busy_o     <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         busy_o     <= (state_nxt_s != ST_IDLE);
         // Ready is high exactly while the FSM sits in RESP.
         if_ready_o <= do_op_s & ~gnt_data_r;
         d_ready_o  <= do_op_s &  gnt_data_r;
         case (state_r)
            ST_IDLE: begin
               if (any_req_s) begin
                  gnt_data_r <= grant_data_s;
                  cnt_r      <= WAIT_INIT;
                  if (grant_data_s) begin
                     op_write_r <= d_write_i;
                     idx_r      <= d_addr_i[DEPTH_LOG2+1:2];
                     wdata_r    <= d_wdata_i;
                     be_r       <= d_be_i;
                  end else begin
                     op_write_r <= 1'b0;
                     idx_r      <= if_addr_i[DEPTH_LOG2+1:2];
                     wdata_r    <= wdata_r;
                     be_r       <= be_r;
                  end
                  // Pointer moves only on a genuine conflict, toward the loser.
                  if (conflict_s && (DATA_PRIORITY == 0)) begin
                     rr_data_r <= ~grant_data_s;
                  end else begin
                     rr_data_r <= rr_data_r;
                  end
               end else begin
                  cnt_r <= cnt_r;
               end
            end
            ST_WAIT: begin
               if (cnt_r != 3'd0) begin
                  cnt_r <= cnt_r - 3'd1;
               end else if (!op_write_r) begin
                  if (gnt_data_r) begin
                     d_rdata_o <= mem_r[idx_r];
                  end else begin
                     if_data_o <= mem_r[idx_r];
                  end
               end else begin
                  cnt_r <= cnt_r;
               end
            end
            ST_RESP: begin
               cnt_r <= cnt_r;
            end
            default: begin
               cnt_r <= 3'd0;
            end
         endcase
      end
   end

   // RAM write port; contents are deliberately not reset.
   always_ff @(posedge clk_i) begin
      if (do_op_s && gnt_data_r && op_write_r) begin
         mem_r[idx_r] <= merge_bytes(mem_r[idx_r], wdata_r, be_r);
      end else begin
         mem_r[idx_r] <= mem_r[idx_r];
      end
   end

endmodule
